// File: rtl/csr_trap_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_trap_pkg : op/state enums, CSR numbers and mstatus trap helper.
// Macro CSR_TRAP_MSTATUS_EN adds the mstatus states. Rev 1.0
// ---------------------------------------------------------------------------
package csr_trap_pkg;

  typedef enum logic [2:0] {
    OP_CSRRW  = 3'd0,
    OP_CSRRS  = 3'd1,
    OP_CSRRC  = 3'd2,
    OP_CSRRWI = 3'd3,
    OP_CSRRSI = 3'd4,
    OP_CSRRCI = 3'd5,
    OP_ECALL  = 3'd6,
    OP_MRET   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_COMMIT = 3'd2
`ifdef CSR_TRAP_MSTATUS_EN
    ,
    ST_MS_READ   = 3'd3,
    ST_MS_COMMIT = 3'd4
`endif
  } state_e;

  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

  function automatic logic is_imm_op(input op_e op);
    return (op == OP_CSRRWI) || (op == OP_CSRRSI) || (op == OP_CSRRCI);
  endfunction

  // Trap entry stacks MIE into MPIE; MRET restores it. MPP is fixed to M-mode.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] ms, input logic is_mret);
    logic [31:0] r;
    r        = ms;
    r[12:11] = 2'b11;
    if (is_mret) begin
      r[3] = ms[7];
      r[7] = 1'b1;
    end else begin
      r[7] = ms[3];
      r[3] = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_trap_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_trap_alu : CSR read-modify-write value and set/clear write suppression.
// Rev 1.0
// ---------------------------------------------------------------------------
module csr_trap_alu
  import csr_trap_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] old_val,
  input  logic [31:0] src,
  input  logic [4:0]  rs1_zimm,
  output logic [31:0] new_val,
  output logic        wr_suppress
);

  always_comb begin
    new_val     = src;
    wr_suppress = 1'b0;
    case (op)
      OP_CSRRS, OP_CSRRSI: begin
        new_val     = old_val | src;
        wr_suppress = (rs1_zimm == 5'd0);
      end
      OP_CSRRC, OP_CSRRCI: begin
        new_val     = old_val & ~src;
        wr_suppress = (rs1_zimm == 5'd0);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_trap_ctrl : Zicsr / ECALL / MRET sequencer, IDLE -> READ -> COMMIT.
// Macro CSR_TRAP_MSTATUS_EN adds MS_READ/MS_COMMIT for mstatus. Rev 1.0
// ---------------------------------------------------------------------------
module csr_trap_ctrl
  import csr_trap_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [11:0] in_csr_addr,
  input  logic [4:0]  in_rs1_zimm,
  input  logic [31:0] in_rs1_data,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        gpr_wen,
  output logic [11:0] csr_waddr1,
  output logic [31:0] csr_wdata1,
  output logic        csr_wen1,
  output logic [11:0] csr_waddr2,
  output logic [31:0] csr_wdata2,
  output logic        csr_wen2,
  output logic        pc_wen,
  output logic [31:0] pc_wdata,
  output logic        done
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] src_q, src_d;
  logic [4:0]  zimm_q, zimm_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d;

  logic [11:0] csr_raddr_q, csr_raddr_d;
  logic [4:0]  gpr_waddr_q, gpr_waddr_d;
  logic [31:0] gpr_wdata_q, gpr_wdata_d;
  logic        gpr_wen_q, gpr_wen_d;
  logic [11:0] csr_waddr1_q, csr_waddr1_d;
  logic [31:0] csr_wdata1_q, csr_wdata1_d;
  logic        csr_wen1_q, csr_wen1_d;
  logic [11:0] csr_waddr2_q, csr_waddr2_d;
  logic [31:0] csr_wdata2_q, csr_wdata2_d;
  logic        csr_wen2_q, csr_wen2_d;
  logic        pc_wen_q, pc_wen_d;
  logic [31:0] pc_wdata_q, pc_wdata_d;
  logic        done_q, done_d;

  logic [31:0] w_new_val;
  logic        w_suppress;
  logic        w_ms_en;

`ifdef CSR_TRAP_MSTATUS_EN
  assign w_ms_en = 1'b1;
`else
  assign w_ms_en = 1'b0;
`endif

  csr_trap_alu u_alu (
    .op          (op_q),
    .old_val     (csr_rdata),
    .src         (src_q),
    .rs1_zimm    (zimm_q),
    .new_val     (w_new_val),
    .wr_suppress (w_suppress)
  );

  // Strobes are registered: the READ cycle computes what COMMIT presents.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    src_d        = src_q;
    zimm_d       = zimm_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    csr_raddr_d  = '0;
    gpr_waddr_d  = '0;
    gpr_wdata_d  = '0;
    gpr_wen_d    = 1'b0;
    csr_waddr1_d = '0;
    csr_wdata1_d = '0;
    csr_wen1_d   = 1'b0;
    csr_waddr2_d = '0;
    csr_wdata2_d = '0;
    csr_wen2_d   = 1'b0;
    pc_wen_d     = 1'b0;
    pc_wdata_d   = '0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op_e'(in_op);
          addr_d  = in_csr_addr;
          zimm_d  = in_rs1_zimm;
          rd_d    = in_rd;
          pc_d    = in_pc;
          src_d   = is_imm_op(op_e'(in_op)) ? {27'b0, in_rs1_zimm} : in_rs1_data;
          state_d = ST_READ;
          case (op_e'(in_op))
            OP_ECALL: csr_raddr_d = CSR_MTVEC;
            OP_MRET:  csr_raddr_d = CSR_MEPC;
            default:  csr_raddr_d = in_csr_addr;
          endcase
        end
      end
      ST_READ: begin
        state_d = ST_COMMIT;
        case (op_q)
          OP_ECALL: begin
            csr_wen1_d   = 1'b1;
            csr_waddr1_d = CSR_MEPC;
            csr_wdata1_d = pc_q;
            csr_wen2_d   = 1'b1;
            csr_waddr2_d = CSR_MCAUSE;
            csr_wdata2_d = MCAUSE_ECALL_M;
            pc_wen_d     = 1'b1;
            pc_wdata_d   = csr_rdata;
            done_d       = !w_ms_en;
          end
          OP_MRET: begin
            pc_wen_d   = 1'b1;
            pc_wdata_d = csr_rdata;
            done_d     = !w_ms_en;
          end
          default: begin
            if (rd_q != 5'd0) begin
              gpr_wen_d   = 1'b1;
              gpr_waddr_d = rd_q;
              gpr_wdata_d = csr_rdata;
            end
            if (!w_suppress) begin
              csr_wen1_d   = 1'b1;
              csr_waddr1_d = addr_q;
              csr_wdata1_d = w_new_val;
            end
            done_d = 1'b1;
          end
        endcase
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
`ifdef CSR_TRAP_MSTATUS_EN
        if ((op_q == OP_ECALL) || (op_q == OP_MRET)) begin
          state_d     = ST_MS_READ;
          csr_raddr_d = CSR_MSTATUS;
        end
`endif
      end
`ifdef CSR_TRAP_MSTATUS_EN
      ST_MS_READ: begin
        state_d      = ST_MS_COMMIT;
        csr_wen1_d   = 1'b1;
        csr_waddr1_d = CSR_MSTATUS;
        csr_wdata1_d = mstatus_trap(csr_rdata, op_q == OP_MRET);
        done_d       = 1'b1;
      end
      ST_MS_COMMIT: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_CSRRW;
      addr_q       <= '0;
      src_q        <= '0;
      zimm_q       <= '0;
      rd_q         <= '0;
      pc_q         <= '0;
      csr_raddr_q  <= '0;
      gpr_waddr_q  <= '0;
      gpr_wdata_q  <= '0;
      gpr_wen_q    <= 1'b0;
      csr_waddr1_q <= '0;
      csr_wdata1_q <= '0;
      csr_wen1_q   <= 1'b0;
      csr_waddr2_q <= '0;
      csr_wdata2_q <= '0;
      csr_wen2_q   <= 1'b0;
      pc_wen_q     <= 1'b0;
      pc_wdata_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      src_q        <= src_d;
      zimm_q       <= zimm_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      csr_raddr_q  <= csr_raddr_d;
      gpr_waddr_q  <= gpr_waddr_d;
      gpr_wdata_q  <= gpr_wdata_d;
      gpr_wen_q    <= gpr_wen_d;
      csr_waddr1_q <= csr_waddr1_d;
      csr_wdata1_q <= csr_wdata1_d;
      csr_wen1_q   <= csr_wen1_d;
      csr_waddr2_q <= csr_waddr2_d;
      csr_wdata2_q <= csr_wdata2_d;
      csr_wen2_q   <= csr_wen2_d;
      pc_wen_q     <= pc_wen_d;
      pc_wdata_q   <= pc_wdata_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign csr_raddr  = csr_raddr_q;
  assign gpr_waddr  = gpr_waddr_q;
  assign gpr_wdata  = gpr_wdata_q;
  assign gpr_wen    = gpr_wen_q;
  assign csr_waddr1 = csr_waddr1_q;
  assign csr_wdata1 = csr_wdata1_q;
  assign csr_wen1   = csr_wen1_q;
  assign csr_waddr2 = csr_waddr2_q;
  assign csr_wdata2 = csr_wdata2_q;
  assign csr_wen2   = csr_wen2_q;
  assign pc_wen     = pc_wen_q;
  assign pc_wdata   = pc_wdata_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_csr_trap_ctrl : directed checks of csr_trap_ctrl against a CSR file model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_csr_trap_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [11:0] in_csr_addr = '0;
  logic [4:0]  in_rs1_zimm = '0;
  logic [31:0] in_rs1_data = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_pc = '0;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        gpr_wen;
  logic [11:0] csr_waddr1;
  logic [31:0] csr_wdata1;
  logic        csr_wen1;
  logic [11:0] csr_waddr2;
  logic [31:0] csr_wdata2;
  logic        csr_wen2;
  logic        pc_wen;
  logic [31:0] pc_wdata;
  logic        done;

`ifdef CSR_TRAP_MSTATUS_EN
  localparam logic TRAP_DONE = 1'b0;
`else
  localparam logic TRAP_DONE = 1'b1;
`endif

  csr_trap_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_csr_addr (in_csr_addr),
    .in_rs1_zimm (in_rs1_zimm),
    .in_rs1_data (in_rs1_data),
    .in_rd       (in_rd),
    .in_pc       (in_pc),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .gpr_waddr   (gpr_waddr),
    .gpr_wdata   (gpr_wdata),
    .gpr_wen     (gpr_wen),
    .csr_waddr1  (csr_waddr1),
    .csr_wdata1  (csr_wdata1),
    .csr_wen1    (csr_wen1),
    .csr_waddr2  (csr_waddr2),
    .csr_wdata2  (csr_wdata2),
    .csr_wen2    (csr_wen2),
    .pc_wen      (pc_wen),
    .pc_wdata    (pc_wdata),
    .done        (done)
  );

  always #5 sys_clk = ~sys_clk;

  // CSR file model: combinational read, writes land on the clock edge.
  logic [31:0] csr_mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign csr_rdata = csr_mem[csr_raddr];

  always @(posedge sys_clk) begin
    if (pre_en)   csr_mem[pre_addr]   <= pre_data;
    if (csr_wen1) csr_mem[csr_waddr1] <= csr_wdata1;
    if (csr_wen2) csr_mem[csr_waddr2] <= csr_wdata2;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  task automatic chk_quiet(input string t);
    check({t, ".strobes"}, 32'({gpr_wen, csr_wen1, csr_wen2, pc_wen, done}), 32'd0);
  endtask

  // Handshake, then the READ cycle; returns positioned in COMMIT.
  task automatic accept(input logic [2:0] op, input logic [11:0] a, input logic [4:0] rz,
                        input logic [31:0] rdat, input logic [4:0] rd, input logic [31:0] pc,
                        input string t, input logic [11:0] exp_raddr);
    check({t, ".accept_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_csr_addr = a; in_rs1_zimm = rz;
    in_rs1_data = rdat; in_rd = rd; in_pc = pc;
    step();
    in_valid = 1'b0; in_op = 3'd1; in_csr_addr = 12'hABC; in_rs1_zimm = 5'd31;
    in_rs1_data = 32'hFFFF_FFFF; in_rd = 5'd31; in_pc = 32'hDEAD_BEEF;
    check({t, ".read_ready"}, 32'(in_ready), 32'd0);
    check({t, ".raddr"}, 32'(csr_raddr), 32'(exp_raddr));
    chk_quiet({t, ".read"});
    step();
  endtask

  task automatic chk_commit(input string t,
                            input logic gw, input logic [4:0] ga, input logic [31:0] gd,
                            input logic w1, input logic [11:0] a1, input logic [31:0] d1,
                            input logic w2, input logic [11:0] a2, input logic [31:0] d2,
                            input logic pw, input logic [31:0] pd, input logic dn);
    check({t, ".ready"}, 32'(in_ready), 32'd0);
    check({t, ".gpr_wen"}, 32'(gpr_wen), 32'(gw));
    if (gw) begin
      check({t, ".gpr_waddr"}, 32'(gpr_waddr), 32'(ga));
      check({t, ".gpr_wdata"}, gpr_wdata, gd);
    end
    check({t, ".csr_wen1"}, 32'(csr_wen1), 32'(w1));
    if (w1) begin
      check({t, ".csr_waddr1"}, 32'(csr_waddr1), 32'(a1));
      check({t, ".csr_wdata1"}, csr_wdata1, d1);
    end
    check({t, ".csr_wen2"}, 32'(csr_wen2), 32'(w2));
    if (w2) begin
      check({t, ".csr_waddr2"}, 32'(csr_waddr2), 32'(a2));
      check({t, ".csr_wdata2"}, csr_wdata2, d2);
    end
    check({t, ".pc_wen"}, 32'(pc_wen), 32'(pw));
    if (pw) check({t, ".pc_wdata"}, pc_wdata, pd);
    check({t, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic chk_idle(input string t);
    check({t, ".ready"}, 32'(in_ready), 32'd1);
    chk_quiet(t);
  endtask

`ifdef CSR_TRAP_MSTATUS_EN
  task automatic ms_phase(input string t, input logic [31:0] exp_ms);
    check({t, ".ms_read_ready"}, 32'(in_ready), 32'd0);
    check({t, ".ms_raddr"}, 32'(csr_raddr), 32'h300);
    chk_quiet({t, ".ms_read"});
    step();
    chk_commit({t, ".ms_commit"}, 1'b0, 5'd0, 32'd0, 1'b1, 12'h300, exp_ms,
               1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state, both while held and after release
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst.ready", 32'(in_ready), 32'd1);
    check("rst.raddr", 32'(csr_raddr), 32'd0);
    chk_quiet("rst");
    check("rst.data", csr_wdata1 | csr_wdata2 | gpr_wdata | pc_wdata, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    step();
    chk_idle("rst.release");

    // CSRRW mtvec, rd=x5
    preset(12'h305, 32'h0);
    accept(3'd0, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 32'd0, "csrrw", 12'h305);
    chk_commit("csrrw", 1'b1, 5'd5, 32'h0, 1'b1, 12'h305, 32'h8000_0100,
               1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
    chk_idle("csrrw.after");
    check("csrrw.mtvec", csr_mem[12'h305], 32'h8000_0100);

    // CSRRS with rs1=x0: read only, no CSR write
    preset(12'h300, 32'h1800);
    accept(3'd1, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd6, 32'd0, "csrrs0", 12'h300);
    chk_commit("csrrs0", 1'b1, 5'd6, 32'h1800, 1'b0, 12'd0, 32'd0,
               1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
    chk_idle("csrrs0.after");

    // CSRRCI mcause, zimm=3, rd=x0
    preset(12'h342, 32'hF);
    accept(3'd5, 12'h342, 5'd3, 32'hFFFF_FFFF, 5'd0, 32'd0, "csrrci", 12'h342);
    chk_commit("csrrci", 1'b0, 5'd0, 32'd0, 1'b1, 12'h342, 32'hC,
               1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
    chk_idle("csrrci.after");

    // ECALL
    preset(12'h305, 32'h8000_0200);
    preset(12'h300, 32'h1808);
    accept(3'd6, 12'h123, 5'd0, 32'd0, 5'd7, 32'h8000_0040, "ecall", 12'h305);
    chk_commit("ecall", 1'b0, 5'd0, 32'd0, 1'b1, 12'h341, 32'h8000_0040,
               1'b1, 12'h342, 32'd11, 1'b1, 32'h8000_0200, TRAP_DONE);
    step();
`ifdef CSR_TRAP_MSTATUS_EN
    ms_phase("ecall", 32'h1880);
`endif
    chk_idle("ecall.after");
    check("ecall.mepc", csr_mem[12'h341], 32'h8000_0040);
    check("ecall.mcause", csr_mem[12'h342], 32'd11);

    // MRET
    preset(12'h341, 32'h8000_0044);
    accept(3'd7, 12'h305, 5'd0, 32'd0, 5'd9, 32'd0, "mret", 12'h341);
    chk_commit("mret", 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0,
               1'b0, 12'd0, 32'd0, 1'b1, 32'h8000_0044, TRAP_DONE);
    step();
`ifdef CSR_TRAP_MSTATUS_EN
    ms_phase("mret", 32'h1888);
`endif
    chk_idle("mret.after");

    // Back-to-back: second op accepted in N+3 sees the first op's write
    preset(12'h340, 32'h0);
    accept(3'd0, 12'h340, 5'd1, 32'h1234_5678, 5'd1, 32'd0, "b2b_w", 12'h340);
    chk_commit("b2b_w", 1'b1, 5'd1, 32'h0, 1'b1, 12'h340, 32'h1234_5678,
               1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
    accept(3'd1, 12'h340, 5'd2, 32'h0000_000F, 5'd2, 32'd0, "b2b_s", 12'h340);
    chk_commit("b2b_s", 1'b1, 5'd2, 32'h1234_5678, 1'b1, 12'h340, 32'h1234_567F,
               1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
    chk_idle("b2b.after");

    // Reset during READ of a CSRRW drops it without any strobe
    in_valid = 1'b1; in_op = 3'd0; in_csr_addr = 12'h305; in_rs1_zimm = 5'd1;
    in_rs1_data = 32'hDEAD_0000; in_rd = 5'd3; in_pc = 32'd0;
    step();
    in_valid = 1'b0;
    check("midrst.in_read", 32'(in_ready), 32'd0);
    sys_rst = 1'b1;
    #1;
    check("midrst.ready", 32'(in_ready), 32'd1);
    check("midrst.raddr", 32'(csr_raddr), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_quiet("midrst.held");
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    step();
    chk_idle("midrst.release");
    check("midrst.mtvec_kept", csr_mem[12'h305], 32'h8000_0200);
    accept(3'd4, 12'h305, 5'd1, 32'd0, 5'd4, 32'd0, "postrst", 12'h305);
    chk_commit("postrst", 1'b1, 5'd4, 32'h8000_0200, 1'b1, 12'h305, 32'h8000_0201,
               1'b0, 12'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    step();
    chk_idle("postrst.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
